// File: rtl/cryo_sched_pkg.sv
// Shared definitions for the counter round-robin scheduler.
//   state_t    : scheduler FSM encoding (IDLE / RUN / DONE), 2 bits
//   onehot()   : index -> one-hot vector (MAX_REQ wide)
//   rr_search(): round-robin winner search, starting at ptr+1 modulo n
package cryo_sched_pkg;

    localparam int unsigned MAX_REQ = 32;

    typedef logic [5:0] idx_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic logic [MAX_REQ-1:0] onehot(input idx_t idx);
        return MAX_REQ'(1) << idx;
    endfunction

    // Returns the first set request after ptr, wrapping at n. ptr < n and
    // i <= n keep ptr+i below 2n, so a single subtraction does the modulo.
    // Returns ptr unchanged when no request is set.
    function automatic idx_t rr_search(input logic [MAX_REQ-1:0] req,
                                       input idx_t ptr, input idx_t n);
        idx_t win;
        idx_t cand;
        logic found;
        win   = ptr;
        found = 1'b0;
        for (int unsigned i = 1; i <= MAX_REQ; i++) begin
            cand = ptr + idx_t'(i);
            if (cand >= n) cand = cand - n;
            if (!found && (i <= 32'(n)) && req[cand[4:0]]) begin
                win   = cand;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/counter_param.sv
// Saturating up-counter shared by the scheduler.
//   clk   : clock, rising edge
//   rst   : synchronous clear (highest priority)
//   en    : count enable, +1 per cycle, holds at MAX_COUNT
//   count : current counter value
module counter_param #(
    parameter int unsigned MAX_COUNT   = 14,
    parameter int unsigned COUNT_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   en,
    output logic [COUNT_WIDTH-1:0] count
);

    localparam logic [COUNT_WIDTH-1:0] MAX_C = COUNT_WIDTH'(MAX_COUNT);

    logic [COUNT_WIDTH-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (en && (count_q != MAX_C)) begin
            count_q <= count_q + COUNT_WIDTH'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/counter_rr_sched.sv
// Round-robin scheduler granting a shared interval counter to one of
// NUM_REQ requesters at a time.
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   req   : per-requester level request (drop to abort)
//   dur   : per-requester duration, slice i = [i*COUNT_WIDTH +: COUNT_WIDTH]
//   grant : one-hot current owner, zero when unowned
//   done  : one-cycle one-hot completion pulse to the owner
//   busy  : high while an interval runs
//   count : live value of the shared counter
module counter_rr_sched
    import cryo_sched_pkg::*;
#(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned COUNT_WIDTH = 4,
    parameter int unsigned MAX_COUNT   = 14
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_REQ-1:0]             req,
    input  logic [NUM_REQ*COUNT_WIDTH-1:0] dur,
    output logic [NUM_REQ-1:0]             grant,
    output logic [NUM_REQ-1:0]             done,
    output logic                           busy,
    output logic [COUNT_WIDTH-1:0]         count
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [COUNT_WIDTH-1:0] MAX_C = COUNT_WIDTH'(MAX_COUNT);

    state_t                 state_q, state_d;
    logic [NUM_REQ-1:0]     grant_q, grant_d;
    logic [NUM_REQ-1:0]     done_q, done_d;
    logic [COUNT_WIDTH-1:0] dur_q, dur_d;
    logic [IDX_W-1:0]       ptr_q, ptr_d;
    logic [IDX_W-1:0]       owner_q, owner_d;
    logic [IDX_W-1:0]       winner;
    logic [COUNT_WIDTH-1:0] dur_win;
    logic                   cnt_en;
    logic                   cnt_clr;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            dur_q   <= '0;
            ptr_q   <= IDX_W'(NUM_REQ - 1);
            owner_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            dur_q   <= dur_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
        end
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        dur_d   = dur_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;
        winner  = IDX_W'(rr_search(MAX_REQ'(req), idx_t'(ptr_q), idx_t'(NUM_REQ)));
        dur_win = dur[winner*COUNT_WIDTH +: COUNT_WIDTH];

        unique case (state_q)
            ST_IDLE: begin
                if (|req) begin
                    state_d = ST_RUN;
                    grant_d = NUM_REQ'(onehot(idx_t'(winner)));
                    dur_d   = (dur_win > MAX_C) ? MAX_C : dur_win;
                    owner_d = winner;
                end
            end
            ST_RUN: begin
                // Abort outranks completion in the same cycle.
                if (!req[owner_q]) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    ptr_d   = owner_q;
                end else if (count == dur_q) begin
                    state_d = ST_DONE;
                    done_d  = grant_q;
                    grant_d = '0;
                    ptr_d   = owner_q;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                grant_d = '0;
            end
        endcase
    end

    // Clearing on the edge that leaves RUN (rather than one cycle later)
    // keeps count at 0 whenever no interval is running.
    assign cnt_en  = (state_q == ST_RUN);
    assign cnt_clr = rst | (state_d != ST_RUN);

    counter_param #(
        .MAX_COUNT   (MAX_COUNT),
        .COUNT_WIDTH (COUNT_WIDTH)
    ) u_counter (
        .clk   (clk),
        .rst   (cnt_clr),
        .en    (cnt_en),
        .count (count)
    );

    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = (state_q == ST_RUN);

endmodule

// File: tb/tb_counter_rr_sched.sv
module tb_counter_rr_sched;

    localparam int NR   = 4;
    localparam int CW   = 4;
    localparam int MAXC = 14;

    logic            clk;
    logic            rst;
    logic [NR-1:0]   req;
    logic [NR*CW-1:0] dur;
    logic [NR-1:0]   grant;
    logic [NR-1:0]   done;
    logic            busy;
    logic [CW-1:0]   count;

    counter_rr_sched #(
        .NUM_REQ     (NR),
        .COUNT_WIDTH (CW),
        .MAX_COUNT   (MAXC)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .dur   (dur),
        .grant (grant),
        .done  (done),
        .busy  (busy),
        .count (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int unsigned grant;
        int unsigned done;
        int unsigned busy;
        int unsigned count;
        bit          count_care;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    // Reference model: who owns the counter, how long it has run, how long
    // it may run, last finished owner, and which requester is in its done cycle.
    int m_owner   = -1;
    int m_elapsed = 0;
    int m_len     = 0;
    int m_ptr     = NR - 1;
    int m_done    = -1;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input logic r, input logic [NR-1:0] q, input logic [NR*CW-1:0] d);
        exp_t e;
        if (r) begin
            m_owner = -1;
            m_done  = -1;
            m_ptr   = NR - 1;
        end else if (m_done >= 0) begin
            m_done = -1;
        end else if (m_owner < 0) begin
            if (q != 0) begin
                for (int k = 1; k <= NR; k++) begin
                    int c;
                    c = (m_ptr + k) % NR;
                    if (m_owner < 0 && q[c]) begin
                        int dv;
                        dv = int'(d[c*CW +: CW]);
                        m_owner   = c;
                        m_len     = (dv > MAXC) ? MAXC : dv;
                        m_elapsed = 0;
                    end
                end
            end
        end else begin
            if (!q[m_owner]) begin
                m_ptr   = m_owner;
                m_owner = -1;
            end else if (m_elapsed == m_len) begin
                m_ptr   = m_owner;
                m_done  = m_owner;
                m_owner = -1;
            end else begin
                m_elapsed++;
            end
        end
        e.grant      = (m_owner >= 0) ? (1 << m_owner) : 0;
        e.done       = (m_done >= 0) ? (1 << m_done) : 0;
        e.busy       = (m_owner >= 0) ? 1 : 0;
        e.count      = (m_owner >= 0) ? m_elapsed : 0;
        e.count_care = (m_done < 0);
        sb.push_back(e);
    endtask

    task automatic tick(input logic r, input logic [NR-1:0] q, input logic [NR*CW-1:0] d);
        @(negedge clk);
        rst = r;
        req = q;
        dur = d;
        @(posedge clk);
        model_step(r, q, d);
    endtask

    // Monitor: pops one expected snapshot per cycle and checks invariants.
    initial begin
        exp_t        e;
        logic [NR-1:0] prev_grant;
        prev_grant = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_grant", grant, e.grant);
                chk("sb_done", done, e.done);
                chk("sb_busy", busy, e.busy);
                if (e.count_care) chk("sb_count", count, e.count);
                chk("inv_grant_onehot0", ($countones(grant) <= 1) ? 1 : 0, 1);
                chk("inv_done_onehot0", ($countones(done) <= 1) ? 1 : 0, 1);
                chk("inv_busy_eq_grant", busy, (grant != 0) ? 1 : 0);
                chk("inv_done_after_grant", done & ~prev_grant, 0);
            end
            prev_grant = grant;
        end
    end

    initial begin
        logic [NR-1:0]    rq;
        logic [NR*CW-1:0] dv;
        rst = 1'b1;
        req = '0;
        dur = '0;

        tick(1, '0, '0);
        tick(1, '0, '0);
        #2;
        chk("reset_grant", grant, 0);
        chk("reset_done", done, 0);
        chk("reset_busy", busy, 0);
        chk("reset_count", count, 0);

        // Single request, dur0 = 5.
        for (int k = 1; k <= 8; k++) begin
            tick(0, 4'b0001, 16'h0005);
            #2;
            if (k == 1) begin chk("single_grant_c1", grant, 1); chk("single_count_c1", count, 0); end
            if (k == 6) begin chk("single_count_c6", count, 5); chk("single_grant_c6", grant, 1); end
            if (k == 7) begin chk("single_done_c7", done, 1); chk("single_grant_c7", grant, 0); end
            if (k == 8) begin chk("single_done_c8", done, 0); chk("single_busy_c8", busy, 0); end
        end
        tick(0, '0, '0);

        // Contention: all request, dur = 2, from reset.
        tick(1, '0, '0);
        for (int k = 1; k <= 21; k++) begin
            tick(0, 4'b1111, 16'h2222);
            #2;
            if (k == 1)  chk("rr_grant_0", grant, 1);
            if (k == 4)  chk("rr_done_0", done, 1);
            if (k == 6)  chk("rr_grant_1", grant, 2);
            if (k == 11) chk("rr_grant_2", grant, 4);
            if (k == 16) chk("rr_grant_3", grant, 8);
            if (k == 21) chk("rr_grant_0_again", grant, 1);
        end
        tick(0, '0, '0);

        // dur = 0.
        tick(1, '0, '0);
        for (int k = 1; k <= 2; k++) begin
            tick(0, 4'b0001, 16'h0000);
            #2;
            if (k == 2) chk("dur0_done_c2", done, 1);
        end
        tick(0, '0, '0);
        tick(0, '0, '0);

        // dur = 15 saturates to 14.
        tick(1, '0, '0);
        for (int k = 1; k <= 16; k++) begin
            tick(0, 4'b0001, 16'h000F);
            #2;
            if (k == 15) chk("sat_count_c15", count, 14);
            if (k == 16) chk("sat_done_c16", done, 1);
        end
        tick(0, '0, '0);
        tick(0, '0, '0);

        // Abort: owner 0 drops at count 3.
        tick(1, '0, '0);
        for (int k = 1; k <= 4; k++) tick(0, 4'b1111, 16'hAAAA);
        #2;
        chk("abort_count_c4", count, 3);
        tick(0, 4'b1110, 16'hAAAA);
        #2;
        chk("abort_grant_c5", grant, 0);
        chk("abort_done_c5", done, 0);
        tick(0, 4'b1110, 16'hAAAA);
        #2;
        chk("abort_next_grant", grant, 2);
        tick(0, '0, '0);
        tick(0, '0, '0);

        // Reset mid-run: owner 1 running, rst at count 4, next winner is 0.
        tick(1, '0, '0);
        for (int k = 1; k <= 3; k++) tick(0, 4'b0001, 16'h0001);
        tick(0, '0, '0);
        for (int k = 1; k <= 5; k++) tick(0, 4'b0011, 16'hAAAA);
        #2;
        chk("rstmid_owner", grant, 2);
        chk("rstmid_count_c4", count, 4);
        tick(1, 4'b0011, 16'hAAAA);
        #2;
        chk("rstmid_grant", grant, 0);
        chk("rstmid_count", count, 0);
        chk("rstmid_busy", busy, 0);
        tick(0, 4'b0011, 16'hAAAA);
        #2;
        chk("rstmid_next_grant", grant, 1);

        // Random traffic.
        rq = '0;
        dv = '0;
        for (int n = 0; n < 3000; n++) begin
            for (int i = 0; i < NR; i++) begin
                if ($urandom_range(0, 15) == 0) rq[i] = ~rq[i];
                if ($urandom_range(0, 3) == 0) dv[i*CW +: CW] = CW'($urandom_range(0, 15));
            end
            tick(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, rq, dv);
        end

        #5;
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
